ex_mem_reg: RTL and testbench

EX_MEM_REG -- requirements
Module: ex_mem_reg

---
 rtl/ex_mem_reg.sv | 128 ++++++++++++
 tb/tb_ex_mem_reg.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register with overflow bookkeeping.
//
// Captures the execute-stage result, store data, destination index and memory/writeback
// controls for the memory stage. A flush turns the captured slot into a bubble, and a stall
// holds everything while the downstream memory is busy. It also keeps a sticky
// signed-overflow flag and a saturating count of overflows committed into the memory stage.
//
// Ports:
//   clk, reset                 clock; asynchronous active-high reset
//   stall, flush               hold / bubble controls (flush wins over stall)
//   ex_valid, ex_alu_result    execute-stage instruction valid and ALU result
//   ex_overflow                signed-overflow flag from the execute adder
//   ex_rs2_data, ex_rd         store data and destination register index
//   ex_ctrl                    {regwrite, memread, memwrite, memtoreg}
//   ovf_clear                  clear sticky overflow flag and counter
//   mem_*                      registered copies of the EX fields
//   mem_fwd_en                 registered result may be forwarded to EX
//   ovf_sticky, ovf_count      overflow flag and saturating overflow count
module ex_mem_reg #(
  parameter int unsigned XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            flush,
  input  logic            ex_valid,
  input  logic [XLEN-1:0] ex_alu_result,
  input  logic            ex_overflow,
  input  logic [XLEN-1:0] ex_rs2_data,
  input  logic [4:0]      ex_rd,
  input  logic [3:0]      ex_ctrl,
  input  logic            ovf_clear,
  output logic            mem_valid,
  output logic [XLEN-1:0] mem_alu_result,
  output logic [XLEN-1:0] mem_rs2_data,
  output logic [4:0]      mem_rd,
  output logic [3:0]      mem_ctrl,
  output logic            mem_fwd_en,
  output logic            ovf_sticky,
  output logic [7:0]      ovf_count
);

  logic            valid_q, valid_d;
  logic [XLEN-1:0] alu_q, alu_d;
  logic [XLEN-1:0] rs2_q, rs2_d;
  logic [4:0]      rd_q, rd_d;
  logic [3:0]      ctrl_q, ctrl_d;
  logic            sticky_q, sticky_d;
  logic [7:0]      count_q, count_d;

  logic load;
  logic commit;

  assign load   = ~flush & ~stall;
  assign commit = load & ex_valid & ex_overflow;

  always_comb begin
    valid_d  = valid_q;
    alu_d    = alu_q;
    rs2_d    = rs2_q;
    rd_d     = rd_q;
    ctrl_d   = ctrl_q;
    sticky_d = sticky_q;
    count_d  = count_q;

    if (flush) begin
      valid_d = 1'b0;
      alu_d   = '0;
      rs2_d   = '0;
      rd_d    = 5'd0;
      ctrl_d  = 4'd0;
    end else if (!stall) begin
      valid_d = ex_valid;
      alu_d   = ex_alu_result;
      rs2_d   = ex_rs2_data;
      rd_d    = ex_rd;
      // Bubbles carry no side effects; writes to x0 are dropped here so later stages
      // and the forwarding path never see them.
      if (ex_valid) begin
        ctrl_d = {ex_ctrl[3] & (ex_rd != 5'd0), ex_ctrl[2:0]};
      end else begin
        ctrl_d = 4'd0;
      end
    end

    // Clear applies even while stalled; a commit on the same edge counts as the first event.
    if (ovf_clear) begin
      sticky_d = commit;
      count_d  = {7'd0, commit};
    end else if (commit) begin
      sticky_d = 1'b1;
      if (count_q != 8'hFF) begin
        count_d = count_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q  <= 1'b0;
      alu_q    <= '0;
      rs2_q    <= '0;
      rd_q     <= 5'd0;
      ctrl_q   <= 4'd0;
      sticky_q <= 1'b0;
      count_q  <= 8'd0;
    end else begin
      valid_q  <= valid_d;
      alu_q    <= alu_d;
      rs2_q    <= rs2_d;
      rd_q     <= rd_d;
      ctrl_q   <= ctrl_d;
      sticky_q <= sticky_d;
      count_q  <= count_d;
    end
  end

  assign mem_valid      = valid_q;
  assign mem_alu_result = alu_q;
  assign mem_rs2_data   = rs2_q;
  assign mem_rd         = rd_q;
  assign mem_ctrl       = ctrl_q;
  // Loads (memtoreg) are not ready until after the memory access, so only ALU writes forward.
  assign mem_fwd_en     = valid_q & ctrl_q[3] & ~ctrl_q[0];
  assign ovf_sticky     = sticky_q;
  assign ovf_count      = count_q;

endmodule

// File: tb/tb_ex_mem_reg.sv
module tb_ex_mem_reg;

  localparam int unsigned XLEN = 64;

  logic            clk;
  logic            reset;
  logic            stall;
  logic            flush;
  logic            ex_valid;
  logic [XLEN-1:0] ex_alu_result;
  logic            ex_overflow;
  logic [XLEN-1:0] ex_rs2_data;
  logic [4:0]      ex_rd;
  logic [3:0]      ex_ctrl;
  logic            ovf_clear;
  logic            mem_valid;
  logic [XLEN-1:0] mem_alu_result;
  logic [XLEN-1:0] mem_rs2_data;
  logic [4:0]      mem_rd;
  logic [3:0]      mem_ctrl;
  logic            mem_fwd_en;
  logic            ovf_sticky;
  logic [7:0]      ovf_count;

  int checks;
  int failures;

  ex_mem_reg #(.XLEN(XLEN)) dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .flush         (flush),
    .ex_valid      (ex_valid),
    .ex_alu_result (ex_alu_result),
    .ex_overflow   (ex_overflow),
    .ex_rs2_data   (ex_rs2_data),
    .ex_rd         (ex_rd),
    .ex_ctrl       (ex_ctrl),
    .ovf_clear     (ovf_clear),
    .mem_valid     (mem_valid),
    .mem_alu_result(mem_alu_result),
    .mem_rs2_data  (mem_rs2_data),
    .mem_rd        (mem_rd),
    .mem_ctrl      (mem_ctrl),
    .mem_fwd_en    (mem_fwd_en),
    .ovf_sticky    (ovf_sticky),
    .ovf_count     (ovf_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ex(input logic v, input logic [XLEN-1:0] alu, input logic ovf,
                        input logic [XLEN-1:0] rs2, input logic [4:0] rd,
                        input logic [3:0] ctrl);
    ex_valid      = v;
    ex_alu_result = alu;
    ex_overflow   = ovf;
    ex_rs2_data   = rs2;
    ex_rd         = rd;
    ex_ctrl       = ctrl;
  endtask

  task automatic test_reset();
    reset = 1'b1; stall = 1'b0; flush = 1'b0; ovf_clear = 1'b0;
    set_ex(1'b1, 64'hDEAD_BEEF, 1'b1, 64'h1234, 5'd3, 4'b1000);
    #1;
    checks++;
    if ({mem_valid, mem_alu_result, mem_rs2_data, mem_rd, mem_ctrl} !== '0) begin
      failures++;
      $display("FAIL reset_fields got v=%0b alu=%0h rs2=%0h rd=%0d ctrl=%b exp all 0",
               mem_valid, mem_alu_result, mem_rs2_data, mem_rd, mem_ctrl);
    end
    checks++;
    if ({mem_fwd_en, ovf_sticky, ovf_count} !== 10'd0) begin
      failures++;
      $display("FAIL reset_flags got fwd=%0b sticky=%0b count=%0d exp 0 0 0",
               mem_fwd_en, ovf_sticky, ovf_count);
    end
    tick();
    checks++;
    if (mem_valid !== 1'b0 || ovf_count !== 8'd0) begin
      failures++;
      $display("FAIL reset_held got v=%0b count=%0d exp 0 0", mem_valid, ovf_count);
    end
    reset = 1'b0;
    set_ex(1'b0, '0, 1'b0, '0, 5'd0, 4'd0);
  endtask

  task automatic test_load();
    set_ex(1'b1, 64'h0000_0000_0000_0005, 1'b0, 64'hAAAA_5555_0000_FFFF, 5'd7, 4'b1000);
    tick();
    checks++;
    if (mem_alu_result !== 64'd5) begin
      failures++;
      $display("FAIL load_alu got=%0h exp=5", mem_alu_result);
    end
    checks++;
    if (mem_rd !== 5'd7) begin
      failures++;
      $display("FAIL load_rd got=%0d exp=7", mem_rd);
    end
    checks++;
    if (mem_fwd_en !== 1'b1 || mem_valid !== 1'b1 || mem_ctrl !== 4'b1000) begin
      failures++;
      $display("FAIL load_ctrl got fwd=%0b v=%0b ctrl=%b exp 1 1 1000",
               mem_fwd_en, mem_valid, mem_ctrl);
    end
    checks++;
    if (mem_rs2_data !== 64'hAAAA_5555_0000_FFFF) begin
      failures++;
      $display("FAIL load_rs2 got=%0h exp=aaaa55550000ffff", mem_rs2_data);
    end
    // memtoreg result is not forwardable; negative value kept bit-exact
    set_ex(1'b1, 64'hFFFF_FFFF_FFFF_FFF0, 1'b0, 64'd0, 5'd31, 4'b1101);
    tick();
    checks++;
    if (mem_fwd_en !== 1'b0 || mem_ctrl !== 4'b1101 || mem_rd !== 5'd31) begin
      failures++;
      $display("FAIL load_memtoreg got fwd=%0b ctrl=%b rd=%0d exp 0 1101 31",
               mem_fwd_en, mem_ctrl, mem_rd);
    end
    checks++;
    if (mem_alu_result !== 64'hFFFF_FFFF_FFFF_FFF0) begin
      failures++;
      $display("FAIL load_alu_neg got=%0h exp=fffffffffffffff0", mem_alu_result);
    end
  endtask

  task automatic test_x0_bubble();
    set_ex(1'b1, 64'h42, 1'b0, 64'h0, 5'd0, 4'b1000);
    tick();
    checks++;
    if (mem_ctrl !== 4'b0000 || mem_valid !== 1'b1 || mem_fwd_en !== 1'b0) begin
      failures++;
      $display("FAIL x0_ctrl got ctrl=%b v=%0b fwd=%0b exp 0000 1 0",
               mem_ctrl, mem_valid, mem_fwd_en);
    end
    set_ex(1'b1, 64'h43, 1'b0, 64'h0, 5'd0, 4'b0110);
    tick();
    checks++;
    if (mem_ctrl !== 4'b0110) begin
      failures++;
      $display("FAIL x0_keep_mem got ctrl=%b exp 0110", mem_ctrl);
    end
    set_ex(1'b0, 64'h99, 1'b0, 64'h77, 5'd9, 4'b1111);
    tick();
    checks++;
    if (mem_valid !== 1'b0 || mem_ctrl !== 4'b0000 || mem_fwd_en !== 1'b0) begin
      failures++;
      $display("FAIL bubble_ctrl got v=%0b ctrl=%b fwd=%0b exp 0 0000 0",
               mem_valid, mem_ctrl, mem_fwd_en);
    end
    checks++;
    if (mem_alu_result !== 64'h99 || mem_rs2_data !== 64'h77 || mem_rd !== 5'd9) begin
      failures++;
      $display("FAIL bubble_data got alu=%0h rs2=%0h rd=%0d exp 99 77 9",
               mem_alu_result, mem_rs2_data, mem_rd);
    end
  endtask

  task automatic test_stall_flush();
    set_ex(1'b1, 64'hA0A0, 1'b0, 64'hB1B1, 5'd12, 4'b1010);
    tick();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_ex(1'b1, 64'h1000 + 64'(i), 1'b1, 64'h2000 + 64'(i), 5'(20 + i), 4'b0101);
      tick();
      checks++;
      if (mem_alu_result !== 64'hA0A0 || mem_rs2_data !== 64'hB1B1 || mem_rd !== 5'd12 ||
          mem_ctrl !== 4'b1010 || mem_valid !== 1'b1) begin
        failures++;
        $display("FAIL stall_hold_%0d got alu=%0h rs2=%0h rd=%0d ctrl=%b v=%0b exp a0a0 b1b1 12 1010 1",
                 i, mem_alu_result, mem_rs2_data, mem_rd, mem_ctrl, mem_valid);
      end
    end
    // Overflow presented while stalled must not commit.
    checks++;
    if (ovf_count !== 8'd0 || ovf_sticky !== 1'b0) begin
      failures++;
      $display("FAIL stall_no_commit got count=%0d sticky=%0b exp 0 0", ovf_count, ovf_sticky);
    end
    flush = 1'b1;
    tick();
    checks++;
    if ({mem_valid, mem_alu_result, mem_rs2_data, mem_rd, mem_ctrl, mem_fwd_en} !== '0) begin
      failures++;
      $display("FAIL stall_flush got v=%0b alu=%0h rs2=%0h rd=%0d ctrl=%b fwd=%0b exp all 0",
               mem_valid, mem_alu_result, mem_rs2_data, mem_rd, mem_ctrl, mem_fwd_en);
    end
    stall = 1'b0; flush = 1'b0;
    set_ex(1'b1, 64'h3, 1'b0, 64'h4, 5'd5, 4'b1000);
    tick();
    checks++;
    if (mem_alu_result !== 64'h3 || mem_rd !== 5'd5 || mem_fwd_en !== 1'b1) begin
      failures++;
      $display("FAIL after_flush_load got alu=%0h rd=%0d fwd=%0b exp 3 5 1",
               mem_alu_result, mem_rd, mem_fwd_en);
    end
  endtask

  task automatic test_overflow();
    set_ex(1'b1, 64'h8000_0000_0000_0000, 1'b1, 64'h0, 5'd1, 4'b1000);
    tick();
    checks++;
    if (ovf_sticky !== 1'b1 || ovf_count !== 8'd1) begin
      failures++;
      $display("FAIL ovf_commit got sticky=%0b count=%0d exp 1 1", ovf_sticky, ovf_count);
    end
    checks++;
    if (mem_alu_result !== 64'h8000_0000_0000_0000) begin
      failures++;
      $display("FAIL ovf_alu got=%0h exp=8000000000000000", mem_alu_result);
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++;
    if (ovf_count !== 8'd1) begin
      failures++;
      $display("FAIL ovf_flushed got count=%0d exp 1", ovf_count);
    end
    ex_valid = 1'b0;
    tick();
    checks++;
    if (ovf_count !== 8'd1) begin
      failures++;
      $display("FAIL ovf_invalid got count=%0d exp 1", ovf_count);
    end
    ex_valid = 1'b1;
    tick();
    checks++;
    if (ovf_count !== 8'd2 || ovf_sticky !== 1'b1) begin
      failures++;
      $display("FAIL ovf_second got count=%0d sticky=%0b exp 2 1", ovf_count, ovf_sticky);
    end
    // Clear applies even while stalled.
    stall = 1'b1; ovf_clear = 1'b1;
    tick();
    stall = 1'b0; ovf_clear = 1'b0;
    checks++;
    if (ovf_count !== 8'd0 || ovf_sticky !== 1'b0) begin
      failures++;
      $display("FAIL ovf_clear_stall got count=%0d sticky=%0b exp 0 0", ovf_count, ovf_sticky);
    end
  endtask

  task automatic test_saturation();
    set_ex(1'b1, 64'h8000_0000_0000_0000, 1'b1, 64'h0, 5'd2, 4'b1000);
    for (int i = 0; i < 300; i++) begin
      tick();
      if (i == 253) begin
        checks++;
        if (ovf_count !== 8'd254) begin
          failures++;
          $display("FAIL sat_254 got count=%0d exp 254", ovf_count);
        end
      end
    end
    checks++;
    if (ovf_count !== 8'd255 || ovf_sticky !== 1'b1) begin
      failures++;
      $display("FAIL sat_255 got count=%0d sticky=%0b exp 255 1", ovf_count, ovf_sticky);
    end
    ovf_clear = 1'b1;
    tick();
    ovf_clear = 1'b0;
    checks++;
    if (ovf_count !== 8'd1 || ovf_sticky !== 1'b1) begin
      failures++;
      $display("FAIL clear_with_commit got count=%0d sticky=%0b exp 1 1", ovf_count, ovf_sticky);
    end
    ex_overflow = 1'b0; ovf_clear = 1'b1;
    tick();
    ovf_clear = 1'b0;
    checks++;
    if (ovf_count !== 8'd0 || ovf_sticky !== 1'b0) begin
      failures++;
      $display("FAIL clear_only got count=%0d sticky=%0b exp 0 0", ovf_count, ovf_sticky);
    end
  endtask

  task automatic test_async_reset();
    set_ex(1'b1, 64'h5555, 1'b1, 64'h6666, 5'd10, 4'b1000);
    tick();
    stall = 1'b1;
    set_ex(1'b1, 64'h7777, 1'b0, 64'h8888, 5'd11, 4'b1000);
    tick();
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if ({mem_valid, mem_alu_result, mem_rs2_data, mem_rd, mem_ctrl, mem_fwd_en,
         ovf_sticky, ovf_count} !== '0) begin
      failures++;
      $display("FAIL async_reset got v=%0b alu=%0h rs2=%0h rd=%0d ctrl=%b fwd=%0b sticky=%0b count=%0d exp all 0",
               mem_valid, mem_alu_result, mem_rs2_data, mem_rd, mem_ctrl, mem_fwd_en,
               ovf_sticky, ovf_count);
    end
    tick();
    reset = 1'b0; stall = 1'b0;
    set_ex(1'b1, 64'h9999, 1'b0, 64'hAAAA, 5'd13, 4'b1000);
    tick();
    checks++;
    if (mem_alu_result !== 64'h9999 || mem_rs2_data !== 64'hAAAA || mem_rd !== 5'd13 ||
        mem_valid !== 1'b1 || mem_fwd_en !== 1'b1) begin
      failures++;
      $display("FAIL reset_then_load got alu=%0h rs2=%0h rd=%0d v=%0b fwd=%0b exp 9999 aaaa 13 1 1",
               mem_alu_result, mem_rs2_data, mem_rd, mem_valid, mem_fwd_en);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_load();
    test_x0_bubble();
    test_stall_flush();
    test_overflow();
    test_saturation();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
